// File: rtl/vend_pkg.sv
// Shared state encoding, item one-hot constants and default timing for the
// vending session arbiter.
package vend_pkg;

    localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
    localparam logic [2:0] ST_GRANT_ENC   = 3'd1;
    localparam logic [2:0] ST_SESSION_ENC = 3'd2;
    localparam logic [2:0] ST_ABORT_ENC   = 3'd3;
    localparam logic [2:0] ST_RELEASE_ENC = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_GRANT   = ST_GRANT_ENC,
        ST_SESSION = ST_SESSION_ENC,
        ST_ABORT   = ST_ABORT_ENC,
        ST_RELEASE = ST_RELEASE_ENC
    } vend_state_e;

    localparam logic [3:0] ITEM0_OH = 4'b0001;
    localparam logic [3:0] ITEM1_OH = 4'b0010;
    localparam logic [3:0] ITEM2_OH = 4'b0100;
    localparam logic [3:0] ITEM3_OH = 4'b1000;

    localparam int TIMEOUT_CYC_DEF = 200;
    localparam int GAP_CYC_DEF     = 2;

    function automatic logic [3:0] item_onehot(input logic [1:0] code);
        case (code)
            2'd0:    return ITEM0_OH;
            2'd1:    return ITEM1_OH;
            2'd2:    return ITEM2_OH;
            default: return ITEM3_OH;
        endcase
    endfunction

endpackage

// File: rtl/vend_rr_pick.sv
// Combinational winner select: round-robin from rr_ptr_i, or lowest index
// first when FIXED_PRIO is set.
module vend_rr_pick #(
    parameter int N_PANELS   = 4,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [N_PANELS-1:0] req_i,
    input  logic [2:0]          rr_ptr_i,
    output logic [2:0]          win_o,
    output logic                valid_o
);

    logic [2:0]          base;
    logic [2:0]          off;
    logic [N_PANELS-1:0] rot;
    logic [3:0]          sum;

    always_comb begin
        base = FIXED_PRIO ? 3'd0 : rr_ptr_i;
        // Rotate so the panel at base lands in bit 0, then take the first set bit.
        rot  = N_PANELS'({req_i, req_i} >> base);
        off  = '0;
        for (int i = N_PANELS - 1; i >= 0; i--) begin
            if (rot[i]) off = 3'(i);
        end
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= 4'(N_PANELS)) sum = sum - 4'(N_PANELS);
        win_o   = sum[2:0];
        valid_o = |req_i;
    end

endmodule

// File: rtl/vend_session_arbiter.sv
// Grants one front panel exclusive use of the vending core until vend, coin
// return or abort. Define ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
//
// state   | meaning
// IDLE    | no session, arbitrate pending requests
// GRANT   | one-cycle item select pulse to the machine
// SESSION | forward owner coins/cancel, watch idle timeout
// ABORT   | one-cycle cancel to the machine
// RELEASE | grant dropped, settle gap before next arbitration
module vend_session_arbiter
    import vend_pkg::*;
#(
    parameter int N_PANELS    = 4,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = 8,
    parameter int GAP_CYC     = GAP_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_PANELS-1:0]   req,
    input  logic [2*N_PANELS-1:0] item_sel,
    input  logic [N_PANELS-1:0]   coin1,
    input  logic [N_PANELS-1:0]   coin2,
    input  logic [N_PANELS-1:0]   cancel,
    input  logic                  vm_pdt,
    input  logic [2:0]            vm_rtn,
    output logic [3:0]            vm_in,
    output logic                  vm_c1,
    output logic                  vm_c2,
    output logic                  vm_cnl,
    output logic [N_PANELS-1:0]   gnt,
    output logic [2:0]            owner,
    output logic                  busy,
    output logic                  timeout_err
);

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    localparam logic [N_PANELS-1:0] GNT_ONE = {{(N_PANELS-1){1'b0}}, 1'b1};

    vend_state_e         state_q;
    logic [N_PANELS-1:0] gnt_q;
    logic [2:0]          owner_q;
    logic [2:0]          rr_ptr_q;
    logic [CNT_W-1:0]    tmo_cnt_q;
    logic [CNT_W-1:0]    gap_q;
    logic [3:0]          vm_in_q;
    logic                vm_c1_q, vm_c2_q, vm_cnl_q, busy_q, tmo_err_q;

    logic [2:0] pick_win;
    logic       pick_valid;
    logic [1:0] item_w;
    logic       own_c1, own_c2, own_cnl, own_req, fwd_c1, fwd_c2;
    logic [2:0] next_ptr;

    vend_rr_pick #(
        .N_PANELS   (N_PANELS),
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .win_o    (pick_win),
        .valid_o  (pick_valid)
    );

    // gnt_q is one-hot on the owner during a session, so it doubles as the select mask.
    always_comb begin
        item_w   = 2'(item_sel >> {pick_win, 1'b0});
        own_c1   = |(coin1 & gnt_q);
        own_c2   = |(coin2 & gnt_q);
        own_cnl  = |(cancel & gnt_q);
        own_req  = |(req & gnt_q);
        fwd_c1   = own_c1 & ~own_c2 & ~own_cnl;
        fwd_c2   = own_c2 & ~own_c1 & ~own_cnl;
        next_ptr = (owner_q == 3'(N_PANELS - 1)) ? 3'd0 : owner_q + 3'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            tmo_cnt_q <= '0;
            gap_q     <= '0;
            vm_in_q   <= '0;
            vm_c1_q   <= 1'b0;
            vm_c2_q   <= 1'b0;
            vm_cnl_q  <= 1'b0;
            busy_q    <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            vm_in_q   <= '0;
            vm_c1_q   <= 1'b0;
            vm_c2_q   <= 1'b0;
            vm_cnl_q  <= 1'b0;
            tmo_err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= GNT_ONE << pick_win;
                        owner_q <= pick_win;
                        busy_q  <= 1'b1;
                        vm_in_q <= item_onehot(item_w);
                    end
                end
                ST_GRANT: begin
                    tmo_cnt_q <= '0;
                    state_q   <= ST_SESSION;
                end
                ST_SESSION: begin
                    if (vm_pdt || (vm_rtn != 3'd0)) begin
                        state_q  <= ST_RELEASE;
                        gnt_q    <= '0;
                        gap_q    <= CNT_W'(GAP_CYC - 1);
                        rr_ptr_q <= next_ptr;
                    end else if (!own_req) begin
                        state_q  <= ST_ABORT;
                        vm_cnl_q <= 1'b1;
                    end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state_q   <= ST_ABORT;
                        vm_cnl_q  <= 1'b1;
                        tmo_err_q <= 1'b1;
                    end else begin
                        vm_c1_q  <= fwd_c1;
                        vm_c2_q  <= fwd_c2;
                        vm_cnl_q <= own_cnl;
                        if (fwd_c1 || fwd_c2)     tmo_cnt_q <= '0;
                        else if (tmo_cnt_q != '1) tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                ST_ABORT: begin
                    state_q  <= ST_RELEASE;
                    gnt_q    <= '0;
                    gap_q    <= CNT_W'(GAP_CYC - 1);
                    rr_ptr_q <= next_ptr;
                end
                ST_RELEASE: begin
                    if (gap_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        owner_q <= '0;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign vm_in       = vm_in_q;
    assign vm_c1       = vm_c1_q;
    assign vm_c2       = vm_c2_q;
    assign vm_cnl      = vm_cnl_q;
    assign gnt         = gnt_q;
    assign owner       = owner_q;
    assign busy        = busy_q;
    assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_vend_session_arbiter.sv
// Directed bench for vend_session_arbiter: vend, contention, isolation,
// timeout, cancel and asynchronous reset, with hand-computed expectations.
module tb_vend_session_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0, coin1 = '0, coin2 = '0, cancel = '0;
    logic [2*N-1:0] item_sel = '0;
    logic           vm_pdt = 1'b0;
    logic [2:0]     vm_rtn = '0;
    logic [3:0]     vm_in;
    logic           vm_c1, vm_c2, vm_cnl, busy, timeout_err;
    logic [N-1:0]   gnt;
    logic [2:0]     owner;

    int total = 0;
    int bad   = 0;

    vend_session_arbiter #(
        .N_PANELS    (N),
        .TIMEOUT_CYC (10),
        .CNT_W       (8),
        .GAP_CYC     (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .item_sel    (item_sel),
        .coin1       (coin1),
        .coin2       (coin2),
        .cancel      (cancel),
        .vm_pdt      (vm_pdt),
        .vm_rtn      (vm_rtn),
        .vm_in       (vm_in),
        .vm_c1       (vm_c1),
        .vm_c2       (vm_c2),
        .vm_cnl      (vm_cnl),
        .gnt         (gnt),
        .owner       (owner),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gnt(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (gnt != '0);
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic grant_and_vend(input string tag, input logic [2:0] exp_own);
        wait_gnt(tag);
        chk({tag, "_owner"}, 32'(owner), 32'(exp_own));
        chk({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << exp_own));
        cyc();
        vm_pdt = 1'b1;
        cyc();
        vm_pdt = 1'b0;
        chk({tag, "_rel"}, 32'(gnt), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        cyc(2);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vm", 32'({vm_in, vm_c1, vm_c2, vm_cnl, timeout_err}), 32'd0);
        rst = 1'b1;
        cyc();
        chk("idle_busy", 32'(busy), 32'd0);

        // normal vend: panel 1, item 2
        req = 4'b0010;
        item_sel = 8'h08;
        cyc();
        chk("nv_gnt", 32'(gnt), 32'b0010);
        chk("nv_owner", 32'(owner), 32'd1);
        chk("nv_busy", 32'(busy), 32'd1);
        chk("nv_vm_in", 32'(vm_in), 32'b0100);
        cyc();
        chk("nv_vm_in_end", 32'(vm_in), 32'd0);
        for (int k = 0; k < 3; k++) begin
            coin2 = 4'b0010;
            cyc();
            chk("nv_c2_hi", 32'(vm_c2), 32'd1);
            coin2 = '0;
            cyc();
            chk("nv_c2_lo", 32'(vm_c2), 32'd0);
        end
        vm_pdt = 1'b1;
        req = '0;
        cyc();
        vm_pdt = 1'b0;
        chk("nv_rel_gnt", 32'(gnt), 32'd0);
        chk("nv_rel_busy1", 32'(busy), 32'd1);
        cyc();
        chk("nv_rel_busy2", 32'(busy), 32'd1);
        cyc();
        chk("nv_idle_busy", 32'(busy), 32'd0);

        // contention with rr_ptr left at 2 by the vend above
        req = 4'b1011;
`ifdef ARB_FIXED_PRIO_EN
        grant_and_vend("ct1_a", 3'd0);
        grant_and_vend("ct1_b", 3'd0);
        grant_and_vend("ct1_c", 3'd0);
`else
        grant_and_vend("ct1_a", 3'd3);
        grant_and_vend("ct1_b", 3'd0);
        grant_and_vend("ct1_c", 3'd1);
`endif
        req = '0;
        cyc(2);
        chk("ct1_idle", 32'(busy), 32'd0);

        // isolation and timeout: owner 0, other panels toggle coins/cancel
        req = 4'b0001;
        wait_gnt("iso");
        chk("iso_owner", 32'(owner), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            coin2  = (k % 2 == 1) ? 4'b1100 : 4'b0100;
            coin1  = 4'b0010;
            cancel = (k % 2 == 1) ? 4'b1000 : 4'b0000;
            cyc();
            chk("iso_c2", 32'(vm_c2), 32'd0);
            chk("iso_c1_cnl", 32'({vm_c1, vm_cnl}), 32'd0);
            chk("iso_no_tmo", 32'(timeout_err), 32'd0);
        end
        coin1 = '0;
        coin2 = '0;
        cancel = '0;
        cyc();
        chk("tmo_err", 32'(timeout_err), 32'd1);
        chk("tmo_cnl", 32'(vm_cnl), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd1);
        req = '0;
        cyc();
        chk("tmo_err_end", 32'(timeout_err), 32'd0);
        chk("tmo_cnl_end", 32'(vm_cnl), 32'd0);
        chk("tmo_rel_gnt", 32'(gnt), 32'd0);
        cyc(2);
        chk("tmo_idle", 32'(busy), 32'd0);

        // cancel together with coin, then coin return ends the session
        req = 4'b0100;
        item_sel = 8'h30;
        wait_gnt("cnl");
        chk("cnl_owner", 32'(owner), 32'd2);
        chk("cnl_vm_in", 32'(vm_in), 32'b1000);
        cyc();
        cancel = 4'b0100;
        coin1  = 4'b0100;
        cyc();
        chk("cnl_cnl", 32'(vm_cnl), 32'd1);
        chk("cnl_c1", 32'(vm_c1), 32'd0);
        cancel = '0;
        cyc();
        chk("c1_only", 32'({vm_c1, vm_cnl}), 32'b10);
        coin2 = 4'b0100;
        cyc();
        chk("dual_coin", 32'({vm_c1, vm_c2}), 32'd0);
        coin1 = '0;
        coin2 = '0;
        vm_rtn = 3'd2;
        cyc();
        vm_rtn = '0;
        req = '0;
        chk("rtn_gnt", 32'(gnt), 32'd0);
        chk("rtn_busy", 32'(busy), 32'd1);
        cyc(2);
        chk("rtn_idle", 32'(busy), 32'd0);

        // asynchronous reset in the middle of a session
        req = 4'b1000;
        item_sel = '0;
        wait_gnt("ar");
        chk("ar_owner", 32'(owner), 32'd3);
        cyc();
        coin1 = 4'b1000;
        cyc();
        chk("ar_c1", 32'(vm_c1), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_gnt", 32'(gnt), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_vm", 32'({vm_in, vm_c1, vm_c2, vm_cnl}), 32'd0);
        coin1 = '0;
        req = 4'b1011;
        cyc(2);
        chk("ar_no_cnl", 32'({vm_cnl, gnt}), 32'd0);
        rst = 1'b1;

        // first grants after reset start from panel 0
`ifdef ARB_FIXED_PRIO_EN
        grant_and_vend("ct2_a", 3'd0);
        grant_and_vend("ct2_b", 3'd0);
        grant_and_vend("ct2_c", 3'd0);
`else
        grant_and_vend("ct2_a", 3'd0);
        grant_and_vend("ct2_b", 3'd1);
        grant_and_vend("ct2_c", 3'd3);
`endif
        req = '0;
        cyc(3);
        chk("end_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vend_session_arbiter.md
Name: vend_session_arbiter

Overview:
- Shares one vending machine core among N_PANELS customer front panels.
- Grants one panel an exclusive session, forwards that panel's item selection, coins and cancel to the machine, and holds the grant until the machine vends (pdt) or returns coins (rtn).
- Aborts stalled sessions on timeout, then re-arbitrates round-robin.
- Sits between the panel I/O and the vending machine core.

Parameters:
- N_PANELS, 4, number of requesting panels (2..8).
- TIMEOUT_CYC, 200, idle cycles allowed in a session before abort.
- CNT_W, 8, timeout counter width; must hold TIMEOUT_CYC.
- GAP_CYC, 2, release cycles before the next grant; lets the machine settle back to IDLE.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_PANELS  per-panel session request (level).
- item_sel  in  2*N_PANELS  per-panel item code 0..3; panel p uses bits [2p+1:2p].
- coin1  in  N_PANELS  per-panel 1-unit coin pulse.
- coin2  in  N_PANELS  per-panel 2-unit coin pulse.
- cancel  in  N_PANELS  per-panel cancel pulse.
- vm_pdt  in  1  machine product-released flag.
- vm_rtn  in  3  machine coin-return count.
- vm_in  out  4  one-hot item select to machine (in0..in3).
- vm_c1  out  1  coin-1 to machine.
- vm_c2  out  1  coin-2 to machine.
- vm_cnl  out  1  cancel to machine.
- gnt  out  N_PANELS  one-hot grant; at most one bit high.
- owner  out  3  index of the granted panel; valid while busy.
- busy  out  1  session in progress (GRANT, SESSION, ABORT or RELEASE).
- timeout_err  out  1  one-cycle pulse when a session is aborted by timeout.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; all outputs 0; rr_ptr=0; tmo_cnt=0. Reset mid-session drops the grant immediately and issues no cancel.
- All outputs are registered. Forwarded inputs reach the machine with 1-cycle latency.
- FSM states: IDLE, GRANT, SESSION, ABORT, RELEASE.
- IDLE:
  - If any req bit is high, select the winner by round-robin starting at rr_ptr.
  - Next cycle: gnt[w]=1, owner=w, busy=1, go to GRANT. Latch item_sel[w] at grant time.
- GRANT (1 cycle):
  - vm_in = one-hot of the latched item code, pulse width exactly 1 cycle.
  - tmo_cnt cleared; go to SESSION.
- SESSION:
  - Forward the owner's coin1/coin2/cancel to vm_c1/vm_c2/vm_cnl.
  - Non-owner coin and cancel inputs are ignored, with no side effects.
  - Owner coin1 and coin2 high in the same cycle: neither is forwarded; the cycle counts as idle.
  - Owner cancel with a coin in the same cycle: only vm_cnl is forwarded.
  - tmo_cnt increments on each cycle without a forwarded coin; it clears on any forwarded coin.
  - Exit priority, highest first:
    1. vm_pdt==1 or vm_rtn!=0 -> RELEASE.
    2. req[owner] dropped -> ABORT.
    3. tmo_cnt==TIMEOUT_CYC-1 -> ABORT, with timeout_err pulsed on entry.
- ABORT (1 cycle): vm_cnl=1, coins 0; go to RELEASE.
- RELEASE:
  - gnt=0 on entry; busy stays 1 for GAP_CYC cycles, then IDLE with busy=0.
  - rr_ptr = owner+1, wrapping to 0 at N_PANELS.
- A new req asserted during a session waits. Its first grant is possible at RELEASE end + 1 cycle.
- tmo_cnt saturates and never wraps.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr unused.
- Undefined (default): round-robin as described above.

Decomposition:
- Shared package vend_pkg holds:
  - The state encoding localparams for IDLE/GRANT/SESSION/ABORT/RELEASE.
  - The item-code-to-one-hot constants.
  - Default TIMEOUT_CYC and GAP_CYC values.
- One sub-module: vend_rr_pick. It is combinational and takes req, rr_ptr, and the ARB_FIXED_PRIO_EN selection; it returns the winner index and a valid flag.

Test Plan:
- Normal vend: req[1]=1, item_sel[1]=2 -> gnt=0010, owner=1, vm_in=0100 for 1 cycle. Then 3 coin2 pulses -> vm_c2 pulses 3x; vm_pdt=1 -> gnt=0 next cycle, busy low after GAP_CYC, rr_ptr=2.
- Contention: req=1011 with rr_ptr=0 -> panels granted in order 0, 1, 3. With ARB_FIXED_PRIO_EN and req[0] held -> panel 0 is re-granted every time.
- Isolation: owner=0; coin2 pulses on panels 2 and 3 -> vm_c2 stays 0, tmo_cnt keeps counting.
- Timeout: TIMEOUT_CYC=10, owner sends no coins -> after 10 SESSION cycles timeout_err=1 for 1 cycle, vm_cnl=1 for 1 cycle, then RELEASE.
- Cancel: owner cancel together with coin1 in the same cycle -> vm_cnl=1, vm_c1=0; vm_rtn=2 -> RELEASE.
- Async reset: rst low mid-SESSION, between clock edges -> gnt, busy and all vm_* outputs go to 0 immediately; after reset, the first grant starts from panel 0.
